// File: rtl/maze_pixel_streamer_if.sv
// Pixel stream from the maze streamer to the display driver.
// The master drives pixels and frame/row markers; the slave returns ready.
interface maze_pixel_streamer_if;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sof;
   logic        pix_eol;
   logic        pix_eof;

   modport master (
      output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
      input  pix_ready
   );

   modport slave (
      input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
      output pix_ready
   );
endinterface

// File: rtl/maze_pixel_streamer.sv
// Maze pixel streamer: walks the frame in row-major order, reads each pixel
// from a registered pattern generator and buffers it in a small FIFO that
// feeds a valid/ready display stream.
//
//   state | meaning
//   IDLE  | waiting for start, index parked at 0
//   FETCH | issuing reads while FIFO credit is available
//   DRAIN | all reads issued, emptying the FIFO; frame_done on exit
module maze_pixel_streamer #(
   parameter int H_PIX      = 96,
   parameter int V_PIX      = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic [12:0]                 index,
   input  logic [15:0]                 data,
   maze_pixel_streamer_if.master       pix,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t          state;
   logic [XW-1:0]   col;
   logic [YW-1:0]   row;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_next;
   logic            inflight;
   logic            fl_sof;
   logic            fl_eol;
   logic            fl_eof;
   logic [18:0]     mem [FIFO_DEPTH];
   logic            rd_fire;
   logic            last_fetch;
   logic            push;
   logic            pop;
   logic            drain_done;

   // Read credit, FIFO occupancy update and frame completion detect.
   // Credit counts the read still in flight so the FIFO can never overflow;
   // a pop in the same cycle does not free credit.
   always_comb begin
      rd_fire    = (state == FETCH) &&
                   ((fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH));
      last_fetch = rd_fire && (row == YW'(V_PIX - 1)) && (col == XW'(H_PIX - 1));
      push       = inflight;
      pop        = (fifo_count != '0) && pix.pix_ready;
      count_next = fifo_count + CW'(push) - CW'(pop);
      drain_done = (state == DRAIN) && !inflight && (count_next == '0);
   end

   // Head of FIFO drives the stream; zeros while empty.
   always_comb begin
      pix.pix_valid = (fifo_count != '0);
      {pix.pix_eof, pix.pix_eol, pix.pix_sof, pix.pix_data} =
         pix.pix_valid ? mem[rd_ptr] : 19'd0;
   end

   // Sequencer: state, address/row/column counters and read tag pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         index      <= '0;
         col        <= '0;
         row        <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         inflight   <= 1'b0;
         fl_sof     <= 1'b0;
         fl_eol     <= 1'b0;
         fl_eof     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         inflight   <= rd_fire;
         if (rd_fire) begin
            fl_sof <= (index == '0);
            fl_eol <= (col == XW'(H_PIX - 1));
            fl_eof <= last_fetch;
            index  <= index + 13'd1;
            if (col == XW'(H_PIX - 1)) begin
               col <= '0;
               row <= (row == YW'(V_PIX - 1)) ? '0 : row + YW'(1);
            end else begin
               col <= col + XW'(1);
            end
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state <= FETCH;
                  busy  <= 1'b1;
               end
            end
            FETCH: begin
               if (last_fetch) state <= DRAIN;
            end
            DRAIN: begin
               if (drain_done) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  index      <= '0;
                  col        <= '0;
                  row        <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= count_next;
      end
   end

   // FIFO storage: generator data lands one cycle after its read, with the
   // flags captured alongside that read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {fl_eof, fl_eol, fl_sof, data};
   end

endmodule

// File: tb/tb_maze_pixel_streamer.sv
// Bench for maze_pixel_streamer: a registered pattern generator, random or
// scripted backpressure, and a reference stream computed from pixel number.
module tb_maze_pixel_streamer;

   localparam int H = 96;
   localparam int V = 64;
   localparam int N = H * V;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [12:0] index;
   logic [15:0] data = 16'd0;
   logic        busy;
   logic        frame_done;

   maze_pixel_streamer_if pix_if ();

   maze_pixel_streamer #(.H_PIX(H), .V_PIX(V), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .index      (index),
      .data       (data),
      .pix        (pix_if),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int k = 0;
   int n_done = 0;
   int last_xfer = 0;
   int ready_mode = 0;
   logic        stalled = 1'b0;
   logic [18:0] held = '0;
   logic [18:0] cur;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (k=%0d cyc=%0d)", tag, obs, exp, k, cyc);
      end
   endtask

   function automatic logic [15:0] gen(input int a);
      int h;
      h = (a * 40503) ^ (a >> 2) ^ 32'h5a3c;
      return h[15:0];
   endfunction

   function automatic logic [18:0] exp_pix(input int p);
      return {(p == N - 1), ((p % H) == H - 1), (p == 0), gen(p)};
   endfunction

   // Pattern generator: registered, one cycle behind the address.
   always @(posedge clk) data <= gen(int'(index));

   always @(posedge clk) cyc++;

   // Stream monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cur = {pix_if.pix_eof, pix_if.pix_eol, pix_if.pix_sof, pix_if.pix_data};
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) check("stall_hold", {pix_if.pix_valid, cur}, {1'b1, held});
         if (pix_if.pix_valid && pix_if.pix_ready) begin
            check("pix", cur, exp_pix(k));
            k++;
            last_xfer = cyc;
         end
         stalled = pix_if.pix_valid && !pix_if.pix_ready;
         held = cur;
         check("fifo_bound", (int'(dut.fifo_count) + int'(dut.inflight) <= DEPTH), 1);
         if (frame_done) begin
            n_done++;
            check("done_gap", cyc - last_xfer, 1);
            check("done_count", k, N);
            check("busy_after_done", busy, 0);
            k = 0;
         end
      end
   end

   // Ready driver: 0 = always ready, 1 = 30% random, 2 = held off.
   initial begin
      pix_if.pix_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       pix_if.pix_ready = 1'b1;
            1:       pix_if.pix_ready = ($urandom_range(0, 99) < 30);
            default: pix_if.pix_ready = 1'b0;
         endcase
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = n_done;
      while (n_done == d0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check("frame_done_seen", n_done, d0 + 1);
   endtask

   task automatic wait_pixels(input int target, input int budget);
      while (k < target && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check("reach_pixel", (k >= target), 1);
   endtask

   initial begin
      int d0;
      #2;
      check("rst_valid", pix_if.pix_valid, 0);
      check("rst_data", {pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol, pix_if.pix_eof}, 0);
      check("rst_index", index, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full-rate frame with latency check.
      ready_mode = 0;
      repeat (2) @(posedge clk);
      pulse_start();
      check("busy_on_start", busy, 1);
      check("lat_valid_c1", pix_if.pix_valid, 0);
      check("index_c1", index, 0);
      @(posedge clk); #1;
      check("lat_valid_c2", pix_if.pix_valid, 0);
      check("index_c2", index, 1);
      @(posedge clk); #1;
      check("lat_valid_c3", pix_if.pix_valid, 1);
      wait_done(N + 200);
      repeat (3) @(posedge clk);
      #1 check("idle_index", index, 0);

      // Random backpressure.
      ready_mode = 1;
      pulse_start();
      wait_done(40000);
      ready_mode = 0;
      repeat (3) @(posedge clk);

      // Long stall right after start.
      ready_mode = 2;
      pulse_start();
      repeat (50) @(posedge clk);
      #1;
      check("stall_index", index, 4);
      check("stall_valid", pix_if.pix_valid, 1);
      check("stall_head", {pix_if.pix_eof, pix_if.pix_eol, pix_if.pix_sof, pix_if.pix_data}, exp_pix(0));
      ready_mode = 0;
      wait_done(N + 200);
      repeat (3) @(posedge clk);

      // Start while busy is ignored.
      pulse_start();
      wait_pixels(100, 1000);
      pulse_start();
      d0 = n_done;
      wait_done(N + 200);
      repeat (30) @(posedge clk);
      #1;
      check("single_done", n_done, d0 + 1);
      check("no_restart_busy", busy, 0);

      // Reset mid-frame.
      pulse_start();
      wait_pixels(3000, 5000);
      @(posedge clk);
      #1 rst_n = 1'b0;
      k = 0;
      #1;
      check("midrst_valid", pix_if.pix_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_index", index, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      d0 = n_done;
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_done", n_done, d0);
      check("midrst_idle", busy, 0);
      check("midrst_valid_idle", pix_if.pix_valid, 0);
      pulse_start();
      wait_done(N + 200);

      // Back-to-back frames.
      repeat (3) @(posedge clk);
      pulse_start();
      wait_done(N + 200);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b_busy", busy, 1);
      wait_done(N + 200);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
